// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the fifo_thresh FIFO family.
package fifo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } fwft_state_t;

    // Pointer and count width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int depth, input int afull_lvl, input int aempty_lvl);
        return (depth >= 4) && ((depth & (depth - 1)) == 0)
            && (afull_lvl >= 0) && (afull_lvl <= depth)
            && (aempty_lvl >= 0) && (aempty_lvl <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with fill level, threshold flags, sticky error flags and an
// optional first-word-fall-through output stage.
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      r_en,
    input  logic                      w_en,
    input  logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic                      r_empty,
    output logic                      w_full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_err,
    output logic                      fwft_state_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

    if (!params_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("fifo_thresh: DEPTH must be a power of two >= 4 and thresholds within 0..DEPTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d, mem_cnt;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d, ram_rdata;
    logic                  r_empty_q, r_empty_d, full_q, full_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc, pop;
    fwft_state_t           state_q, state_d;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (w_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Handshake: on an edge with clk_en high, a push is taken when w_en is high
    // and the FIFO is not full (or a pop frees a slot on the same edge); a pop is
    // taken when r_en is high and r_empty is low. Any other request is dropped
    // and recorded in the sticky overflow/underflow flags.
    always_comb begin
        rd_acc   = clk_en & r_en & ~r_empty_q;
        wr_acc   = clk_en & w_en & (~full_q | rd_acc);
        mem_cnt  = wr_ptr_q - rd_ptr_q;
        state_d  = state_q;
        r_data_d = r_data_q;
        pop      = 1'b0;

        if (FWFT) begin
            // The output stage pulls from storage; pop moves rd_ptr, not the user read.
            if (clk_en) begin
                case (state_q)
                    EMPTY: begin
                        if (mem_cnt != '0) begin
                            pop     = 1'b1;
                            state_d = VALID;
                        end
                    end
                    VALID: begin
                        if (rd_acc) begin
                            if (mem_cnt != '0) begin
                                pop = 1'b1;
                            end else begin
                                state_d = EMPTY;
                            end
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
            if (pop) begin
                r_data_d = ram_rdata;
            end
        end else begin
            pop = rd_acc;
            if (rd_acc) begin
                r_data_d = ram_rdata;
            end
        end

        wr_ptr_d  = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + PW'(wr_acc) - PW'(rd_acc);
        full_d    = (count_d == DEPTH_C);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);
        r_empty_d = FWFT ? (state_d == EMPTY) : (count_d == '0);

        if (clk_en & clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (clk_en & w_en & full_q & ~rd_acc);
            unf_d = unf_q | (clk_en & r_en & r_empty_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            r_data_q  <= '0;
            r_empty_q <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            state_q   <= EMPTY;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            r_data_q  <= r_data_d;
            r_empty_q <= r_empty_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            state_q   <= state_d;
        end
    end

    assign r_data       = r_data_q;
    assign r_empty      = r_empty_q;
    assign w_full       = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign fwft_state_o = (state_q == VALID);

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: registered-read and FWFT instances on shared stimulus,
// checked every cycle against queue-based models plus directed literal expectations.
module tb_fifo_thresh;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en, r_en, w_en, clear_err;
    logic [DW-1:0] w_data;

    logic [DW-1:0] r_rdata, f_rdata;
    logic          r_empty, r_full, r_af, r_ae, r_ovf, r_unf, r_state;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf, f_state;
    logic [CW-1:0] r_count, f_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut_reg (
        .clk(clk), .reset(reset), .clk_en(clk_en), .r_en(r_en), .w_en(w_en),
        .w_data(w_data), .r_data(r_rdata), .r_empty(r_empty), .w_full(r_full),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf), .clear_err(clear_err),
        .fwft_state_o(r_state)
    );

    fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut_fw (
        .clk(clk), .reset(reset), .clk_en(clk_en), .r_en(r_en), .w_en(w_en),
        .w_data(w_data), .r_data(f_rdata), .r_empty(f_empty), .w_full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clear_err(clear_err),
        .fwft_state_o(f_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- models ----------------
    logic [DW-1:0] exp_q[$];   // registered-mode contents, head first
    logic [DW-1:0] r_data_m;
    bit            ovf_r, unf_r;
    logic [DW-1:0] fw_q[$];    // FWFT words still behind the output stage
    logic [DW-1:0] f_data_m;
    bit            f_valid, ovf_f, unf_f;

    function automatic void model_reset();
        exp_q.delete();
        fw_q.delete();
        r_data_m = '0;
        f_data_m = '0;
        f_valid  = 1'b0;
        ovf_r = 1'b0; unf_r = 1'b0;
        ovf_f = 1'b0; unf_f = 1'b0;
    endfunction

    function automatic void model_step();
        int  n, s;
        bit  rd, wr, set_o, set_u;
        // registered read: a read returns the head one edge later
        n     = exp_q.size();
        rd    = r_en && (n != 0);
        wr    = w_en && ((n != DEPTH) || rd);
        set_o = w_en && (n == DEPTH) && !rd;
        set_u = r_en && (n == 0);
        if (clear_err) begin ovf_r = 1'b0; unf_r = 1'b0; end
        else begin ovf_r = ovf_r | set_o; unf_r = unf_r | set_u; end
        if (rd) r_data_m = exp_q.pop_front();
        if (wr) exp_q.push_back(w_data);
        // FWFT: output stage shows a word one edge after it lands in storage
        s     = fw_q.size();
        n     = s + int'(f_valid);
        rd    = r_en && f_valid;
        wr    = w_en && ((n != DEPTH) || rd);
        set_o = w_en && (n == DEPTH) && !rd;
        set_u = r_en && !f_valid;
        if (clear_err) begin ovf_f = 1'b0; unf_f = 1'b0; end
        else begin ovf_f = ovf_f | set_o; unf_f = unf_f | set_u; end
        if (!f_valid) begin
            if (s > 0) begin f_data_m = fw_q.pop_front(); f_valid = 1'b1; end
        end else if (rd) begin
            if (s > 0) f_data_m = fw_q.pop_front();
            else f_valid = 1'b0;
        end
        if (wr) fw_q.push_back(w_data);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else if (clk_en) model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_on && reset === 1'b1) begin
            chk("reg_count",   32'(r_count), exp_q.size());
            chk("reg_empty",   32'(r_empty), 32'(exp_q.size() == 0));
            chk("reg_full",    32'(r_full),  32'(exp_q.size() == DEPTH));
            chk("reg_afull",   32'(r_af),    32'(exp_q.size() >= DEPTH - 2));
            chk("reg_aempty",  32'(r_ae),    32'(exp_q.size() <= 2));
            chk("reg_ovf",     32'(r_ovf),   32'(ovf_r));
            chk("reg_unf",     32'(r_unf),   32'(unf_r));
            chk("reg_rdata",   32'(r_rdata), 32'(r_data_m));
            chk("reg_state",   32'(r_state), 32'd0);
            chk("fw_count",    32'(f_count), fw_q.size() + int'(f_valid));
            chk("fw_empty",    32'(f_empty), 32'(!f_valid));
            chk("fw_full",     32'(f_full),  32'(fw_q.size() + int'(f_valid) == DEPTH));
            chk("fw_afull",    32'(f_af),    32'(fw_q.size() + int'(f_valid) >= DEPTH - 2));
            chk("fw_aempty",   32'(f_ae),    32'(fw_q.size() + int'(f_valid) <= 2));
            chk("fw_ovf",      32'(f_ovf),   32'(ovf_f));
            chk("fw_unf",      32'(f_unf),   32'(unf_f));
            chk("fw_state",    32'(f_state), 32'(f_valid));
            if (f_valid) chk("fw_rdata", 32'(f_rdata), 32'(f_data_m));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic ce, input logic re, input logic we,
                        input logic [DW-1:0] wd, input logic clr);
        clk_en = ce; r_en = re; w_en = we; w_data = wd; clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        clk_en = 1'b0; r_en = 1'b0; w_en = 1'b0; w_data = '0; clear_err = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        cmp_on = 1'b1;

        // reset state
        chk("rst_count",  32'(r_count), 32'd0);
        chk("rst_empty",  32'(r_empty), 32'd1);
        chk("rst_full",   32'(r_full),  32'd0);
        chk("rst_aempty", 32'(r_ae),    32'd1);
        chk("rst_rdata",  32'(r_rdata), 32'd0);
        chk("rst_fempty", 32'(f_empty), 32'd1);

        // write 15, 69, 42 then read three
        step(1, 0, 1, 8'd15, 0);
        step(1, 0, 1, 8'd69, 0);
        step(1, 0, 1, 8'd42, 0);
        step(1, 1, 0, 8'd0, 0);  chk("rd1", 32'(r_rdata), 32'd15);
        step(1, 1, 0, 8'd0, 0);  chk("rd2", 32'(r_rdata), 32'd69);
        step(1, 1, 0, 8'd0, 0);  chk("rd3", 32'(r_rdata), 32'd42);
        chk("rd3_empty", 32'(r_empty), 32'd1);
        chk("rd3_unf",   32'(r_unf),   32'd0);
        step(1, 0, 0, 8'd0, 0);

        // fill to 16, then one extra write
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 1, DW'(i), 0);
            if (i == 12) chk("afull_at13", 32'(r_af), 32'd0);
            if (i == 13) chk("afull_at14", 32'(r_af), 32'd1);
        end
        chk("full_flag",  32'(r_full),  32'd1);
        chk("full_count", 32'(r_count), 32'd16);
        chk("fw_full_count", 32'(f_count), 32'd16);
        step(1, 0, 1, 8'd77, 0);
        chk("ovf_set",   32'(r_ovf),   32'd1);
        chk("ovf_count", 32'(r_count), 32'd16);
        step(1, 0, 0, 8'd0, 1);
        chk("ovf_clr",   32'(r_ovf),   32'd0);

        // read and write together while full
        step(1, 1, 1, 8'd99, 0);
        chk("rw_full_count", 32'(r_count), 32'd16);
        chk("rw_full_ovf",   32'(r_ovf),   32'd0);
        chk("rw_full_full",  32'(r_full),  32'd1);
        chk("rw_full_rdata", 32'(r_rdata), 32'd0);
        chk("fw_rw_count",   32'(f_count), 32'd16);
        for (int i = 1; i < DEPTH; i++) begin
            step(1, 1, 0, 8'd0, 0);
            chk("drain", 32'(r_rdata), 32'(i));
        end
        step(1, 1, 0, 8'd0, 0);
        chk("drain_last",  32'(r_rdata), 32'd99);
        chk("drain_empty", 32'(r_empty), 32'd1);

        // underflow is sticky until clear_err
        step(1, 1, 0, 8'd0, 0);  chk("unf_set",  32'(r_unf), 32'd1);
        step(1, 0, 0, 8'd0, 0);  chk("unf_hold", 32'(r_unf), 32'd1);
        step(1, 0, 0, 8'd0, 1);  chk("unf_clr",  32'(r_unf), 32'd0);

        // FWFT fall-through latency
        step(1, 0, 1, 8'hA5, 0); chk("fw_lat1_empty", 32'(f_empty), 32'd1);
        step(1, 0, 0, 8'd0, 0);
        chk("fw_lat2_empty", 32'(f_empty), 32'd0);
        chk("fw_lat2_data",  32'(f_rdata), 32'hA5);
        step(1, 1, 0, 8'd0, 0);
        chk("fw_pop_empty",  32'(f_empty), 32'd1);
        chk("reg_a5",        32'(r_rdata), 32'hA5);

        // clock-enable hold, then asynchronous reset mid-stream
        step(1, 1, 0, 8'd0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, DW'(i * 3 + 1), 0);
        step(1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 6; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1);
        chk("ce_hold_count", 32'(r_count), 32'd8);
        chk("ce_hold_unf",   32'(r_unf),   32'd1);
        chk("ce_hold_fcnt",  32'(f_count), 32'd8);
        clk_en = 1'b1; r_en = 1'b1; w_en = 1'b1;
        reset = 1'b0;
        #1;
        chk("arst_count",  32'(r_count), 32'd0);
        chk("arst_empty",  32'(r_empty), 32'd1);
        chk("arst_unf",    32'(r_unf),   32'd0);
        chk("arst_ovf",    32'(r_ovf),   32'd0);
        chk("arst_fcount", 32'(f_count), 32'd0);
        chk("arst_fempty", 32'(f_empty), 32'd1);
        chk("arst_funf",   32'(f_unf),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 0, 1, 8'h3C, 0);
        chk("post_rst_count", 32'(r_count), 32'd1);
        step(1, 1, 0, 8'd0, 0);
        chk("post_rst_data",  32'(r_rdata), 32'h3C);

        // randomized traffic with shifting read/write bias
        pw = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) pw = $urandom_range(10, 90);
            step(1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 99) >= pw),
                 1'($urandom_range(0, 99) < pw),
                 DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 19) == 0));
        end
        step(1, 0, 0, 8'd0, 0);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_thresh.md
# fifo_thresh

Parametrised synchronous FIFO, the successor to the basic `fifo` block. It adds a fill-level output, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. A build-time mode selects either registered-read or first-word-fall-through (FWFT) output. It sits between producer and consumer logic in a single clock domain and keeps the `fifo` clock-enable and read/write-enable handshake.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 4.
- `FWFT`, 1'b0: 0 = registered read, 1 = first-word-fall-through.
- `AFULL_LVL`, DEPTH-2: `almost_full` asserts when count ≥ AFULL_LVL.
- `AEMPTY_LVL`, 2: `almost_empty` asserts when count ≤ AEMPTY_LVL.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  global enable; when low, all state holds and `r_en`/`w_en` are ignored.
- `r_en`  in  1  read/pop request.
- `w_en`  in  1  write/push request.
- `w_data`  in  DATA_WIDTH  write data.
- `r_data`  out  DATA_WIDTH  read data.
- `r_empty`  out  1  FIFO holds no readable word.
- `w_full`  out  1  FIFO holds DEPTH words.
- `almost_full`  out  1  threshold flag.
- `almost_empty`  out  1  threshold flag.
- `count`  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full and not accepted.
- `underflow`  out  1  sticky: a read was attempted while empty.
- `clear_err`  in  1  synchronous clear of `overflow` and `underflow`; qualified by `clk_en`.

## Operation
- Read and write pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit. The low bits address storage and wrap from DEPTH-1 to 0.
- `count` = wr_ptr − rd_ptr, modulo 2^(ptr width).
- Write accepted = `clk_en & w_en & (!w_full | rd_accept)`. An accepted write stores `w_data` at wr_ptr and increments wr_ptr.
- Read accepted (rd_accept) = `clk_en & r_en & !r_empty`. An accepted read increments rd_ptr.
- Full with simultaneous read and write: both are accepted, `count` is unchanged, `w_full` stays high.
- Empty with simultaneous read and write: the write is accepted, the read is rejected, and `underflow` sets.
- `overflow` sets on `clk_en & w_en & w_full & !rd_accept`.
- `underflow` sets on `clk_en & r_en & r_empty`.
- `clear_err` has priority over a same-cycle set.
- Registered mode (FWFT=0):
  - An accepted read loads `r_data` with the head word on the same edge.
  - `r_data` holds its value otherwise.
  - `r_empty` = (count == 0).
- FWFT mode:
  - Output stage state machine with states EMPTY and VALID.
    - EMPTY → VALID when storage is non-empty; the head word is preloaded into `r_data`.
    - VALID → EMPTY when a read is accepted and storage has no further word.
    - VALID → VALID when a read is accepted and another word exists; the next word is loaded.
  - `r_empty` = (state == EMPTY).
  - `count` includes the word held in the output stage.
- `clear_err` does not change the FIFO contents.

## Timing
- Reset values: pointers 0, `count` 0, `r_data` 0, `r_empty` 1, `w_full` 0, `almost_full` 0, `almost_empty` 1, `overflow` 0, `underflow` 0; FWFT state EMPTY.
- Reset mid-operation discards all contents immediately (asynchronous). The first write after reset release is accepted normally.
- Registered mode: `r_data` is valid 1 cycle after the accepting edge.
- FWFT mode: a write into an empty FIFO makes `r_data` valid and drops `r_empty` 2 edges after the write edge: 1 edge for storage, 1 for the output preload.
- All flags and `count` are registered and reflect accepted operations from the same edge.
- Sustained throughput is 1 read plus 1 write per enabled cycle.

## Structure
- Package `fifo_pkg`:
  - pointer/count width function `ptr_w(DEPTH)`.
  - FWFT state enum `fwft_state_t` {EMPTY, VALID}.
  - parameter-legality check macro or function for DEPTH and the threshold parameters.
- Sub-module `fifo_ram`: DEPTH × DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
- Top level contains the pointers, flags, error logic and FWFT output stage.

## Test plan
- Write 15, 69, 42, then read 3 (FWFT=0) → `r_data` is 15, 69, 42 on successive cycles after each accepted read; `r_empty`=1 after the 3rd read; `underflow`=0.
- Write 16 words 0..15 (DEPTH=16) → `w_full`=1 and `count`=16; `almost_full`=1 from count 14; a 17th write sets `overflow` and `count` stays 16; read-back returns 0..15 in order.
- While full, assert r_en and w_en together with w_data=99 → `count` stays 16, `overflow` stays 0, and 99 is read out last.
- Read while empty → `underflow`=1 and stays set until `clear_err`; assert `clear_err` → 0 on the next edge.
- FWFT=1: write 0xA5 into an empty FIFO → `r_data`=0xA5 with `r_empty`=0 two edges later, without r_en; r_en for one cycle → `r_empty`=1.
- Fill 8 words, hold `clk_en`=0 while toggling r_en/w_en → no state change; assert `reset`=0 mid-stream → `count`=0 and `r_empty`=1 immediately, and all error flags clear.
